// File: rtl/aes_custom_issue_ctrl.sv
// aes_custom_issue_ctrl
// Issue controller for custom-0 AES instructions held in decode. Stages
// the 128-bit key and data words from 32-bit register operands, launches
// the AES engine for ENC/DEC, and holds aes_done low so the decode-stage
// scoreboard stalls until the instruction is allowed to retire. RDW reads
// back one 32-bit word of the last engine result.
//
// Optional feature macro: AES_DEC_EN
//   defined   : funct3 = 011 (DEC) starts the engine with eng_mode = 1
//   undefined : funct3 = 011 is illegal and eng_mode is tied to 0
module aes_custom_issue_ctrl #(
    parameter int TIMEOUT     = 64,
    parameter bit RESULT_HOLD = 1'b1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [6:0]   op_code,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic [31:0]  rs1_data,
    input  logic         kill,
    input  logic         adv,
    output logic         aes_done,
    output logic [31:0]  rd_data,
    output logic         aes_err,
    output logic         eng_start,
    output logic         eng_mode,
    output logic [127:0] eng_key,
    output logic [127:0] eng_din,
    input  logic         eng_valid,
    input  logic [127:0] eng_dout
);

    localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

    localparam logic [2:0] F3_KEYW = 3'b000;
    localparam logic [2:0] F3_DATW = 3'b001;
    localparam logic [2:0] F3_ENC  = 3'b010;
    localparam logic [2:0] F3_DEC  = 3'b011;
    localparam logic [2:0] F3_RDW  = 3'b100;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The abort fires on the edge where the counter steps onto this value.
    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

`ifdef AES_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic [1:0]   state_q;
    logic [1:0]   state_d;
    logic [6:0]   cnt_q;
    logic [127:0] result_q;

    logic         hit;
    logic         idle;
    logic         is_start_op;
    logic         is_illegal;
    logic         wr_key;
    logic         wr_dat;
    logic         cnt_expire;
    logic         eng_accept;
    logic [1:0]   word_idx;
    logic [6:0]   bit_base;
    logic         unused_funct7;

    assign hit      = (op_code == OP_CUSTOM0) && !kill;
    assign idle     = (state_q == ST_IDLE);
    assign word_idx = funct7[1:0];
    assign bit_base = {word_idx, 5'd0};

    assign unused_funct7 = ^funct7[6:2];

    assign is_start_op = hit && ((funct3 == F3_ENC) || (DEC_EN && (funct3 == F3_DEC)));
    assign is_illegal  = hit && ((funct3 > F3_RDW) || (!DEC_EN && (funct3 == F3_DEC)));

    assign wr_key = idle && hit && adv && (funct3 == F3_KEYW);
    assign wr_dat = idle && hit && adv && (funct3 == F3_DATW);

    // A completion only counts while the operation is still alive in BUSY;
    // if it coincides with the timeout, the completion takes priority.
    assign cnt_expire = ((cnt_q + 7'd1) == CNT_LAST);
    assign eng_accept = (state_q == ST_BUSY) && !kill && eng_valid;

    // Next-state selection for the ENC/DEC launch sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (is_start_op) state_d = ST_START;
            ST_START: state_d = kill ? ST_IDLE : ST_BUSY;
            ST_BUSY: begin
                if (kill)                         state_d = ST_IDLE;
                else if (eng_valid || cnt_expire) state_d = ST_DONE;
            end
            ST_DONE:  if (adv || kill) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register, single-cycle start pulse and BUSY cycle counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            eng_start <= 1'b0;
            cnt_q     <= 7'd0;
        end else begin
            state_q   <= state_d;
            eng_start <= (state_q == ST_IDLE) && (state_d == ST_START);
            if (state_q == ST_START)
                cnt_q <= 7'd0;
            else if (state_q == ST_BUSY)
                cnt_q <= cnt_q + 7'd1;
        end
    end

`ifdef AES_DEC_EN
    // Capture the direction of the operation being launched
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            eng_mode <= 1'b0;
        else if (idle && is_start_op)
            eng_mode <= (funct3 == F3_DEC);
    end
`else
    assign eng_mode = 1'b0;
`endif

    // Key staging register, one 32-bit word per retiring KEYW
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            eng_key <= '0;
        else if (wr_key)
            eng_key[bit_base +: 32] <= rs1_data;
    end

    // Data-in staging register, one 32-bit word per retiring DATW
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            eng_din <= '0;
        else if (wr_dat)
            eng_din[bit_base +: 32] <= rs1_data;
    end

    // Result register: loaded only by a completion of a live operation
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            result_q <= '0;
        else if (eng_accept)
            result_q <= eng_dout;
        else if (!RESULT_HOLD && (wr_key || wr_dat))
            result_q <= '0;
    end

    // Sticky error flag: illegal sub-op retiring, or BUSY timeout abort
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            aes_err <= 1'b0;
        else if ((idle && is_illegal && adv) ||
                 ((state_q == ST_BUSY) && !kill && !eng_valid && cnt_expire))
            aes_err <= 1'b1;
    end

    // Retire permission seen by the decode scoreboard
    always_comb begin
        aes_done = 1'b1;
        case (state_q)
            ST_IDLE:  aes_done = !is_start_op;
            ST_START: aes_done = 1'b0;
            ST_BUSY:  aes_done = 1'b0;
            ST_DONE:  aes_done = 1'b1;
            default:  aes_done = 1'b1;
        endcase
    end

    // RDW read-back word, zero when no RDW is being decoded
    always_comb begin
        rd_data = 32'd0;
        if (idle && hit && (funct3 == F3_RDW))
            rd_data = result_q[bit_base +: 32];
    end

endmodule

// File: tb/tb_aes_custom_issue_ctrl.sv
// tb_aes_custom_issue_ctrl
// Scoreboard bench: stimulus pushes expected retirements and engine starts
// into queues; independent monitors pop and compare when the DUT retires an
// instruction or pulses eng_start. A small engine model answers starts.
`timescale 1ns/1ps
module tb_aes_custom_issue_ctrl;

    localparam logic [6:0] CUSTOM0 = 7'b0001011;
    localparam logic [6:0] NOP_OP  = 7'b0010011;
    localparam logic [2:0] F_KEYW  = 3'b000;
    localparam logic [2:0] F_DATW  = 3'b001;
    localparam logic [2:0] F_ENC   = 3'b010;
    localparam logic [2:0] F_DEC   = 3'b011;
    localparam logic [2:0] F_RDW   = 3'b100;
    localparam logic [2:0] F_BAD   = 3'b111;

    logic         clk = 1'b0;
    logic         nrst;
    logic [6:0]   op_code;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [31:0]  rs1_data;
    logic         kill;
    logic         adv;
    logic         aes_done;
    logic [31:0]  rd_data;
    logic         aes_err;
    logic         eng_start;
    logic         eng_mode;
    logic [127:0] eng_key;
    logic [127:0] eng_din;
    logic         eng_valid;
    logic [127:0] eng_dout;

    typedef struct {
        string       name;
        int          stall;
        logic [31:0] rd;
        logic        err;
    } retire_t;

    retire_t retire_q[$];
    logic    start_q[$];

    int checks = 0;
    int errors = 0;

    int           eng_lat    = 10;
    bit           eng_silent = 1'b0;
    logic [127:0] eng_result = '0;

    logic [127:0] r_enc1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [127:0] r_enc2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    logic [127:0] r_enc3 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    logic [127:0] r_dec  = 128'h13579BDF_2468ACE0_FDB97531_0ECA8642;
    logic [127:0] r_enc5 = 128'hCAFEF00D_12345678_9ABCDEF0_0BADC0DE;
    logic [127:0] r_dead = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    logic [127:0] r_enc6 = 128'h76543210_FEDCBA98_01234567_89ABCDEF;

    logic [31:0] key_words [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    logic [31:0] din_words [4] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};

    aes_custom_issue_ctrl dut (
        .clk       (clk),
        .nrst      (nrst),
        .op_code   (op_code),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1_data  (rs1_data),
        .kill      (kill),
        .adv       (adv),
        .aes_done  (aes_done),
        .rd_data   (rd_data),
        .aes_err   (aes_err),
        .eng_start (eng_start),
        .eng_mode  (eng_mode),
        .eng_key   (eng_key),
        .eng_din   (eng_din),
        .eng_valid (eng_valid),
        .eng_dout  (eng_dout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expectRetire(input string name, input int stall,
                                input logic [31:0] rd, input logic err);
        retire_t e;
        e.name  = name;
        e.stall = stall;
        e.rd    = rd;
        e.err   = err;
        retire_q.push_back(e);
    endtask

    // Presents one instruction from a negedge; adv mirrors aes_done as a
    // pipeline with no other stall source would. Returns at a negedge.
    task automatic applyStimulus(input logic [2:0] f3, input logic [1:0] idx,
                                 input logic [31:0] data, input int kill_at);
        int cyc = 0;
        bit fin = 1'b0;
        op_code  = CUSTOM0;
        funct3   = f3;
        funct7   = {5'd0, idx};
        rs1_data = data;
        kill     = 1'b0;
        adv      = 1'b0;
        while (!fin) begin
            if (cyc == kill_at) kill = 1'b1;
            #1;
            adv = aes_done && !kill;
            @(posedge clk);
            if (adv || kill) begin
                fin = 1'b1;
            end else if (cyc >= 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL watchdog: still stalled after %0d cycles, required retirement", cyc);
                fin = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        op_code  = NOP_OP;
        funct3   = 3'd0;
        funct7   = 7'd0;
        rs1_data = 32'd0;
        kill     = 1'b0;
        adv      = 1'b0;
    endtask

    task automatic pulseReset();
        nrst = 1'b0;
        #1;
        checkOutput("reset clears aes_err", 128'(aes_err), 128'd0);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // Engine model: answers each start after eng_lat cycles unless silent
    initial begin : engine_model
        eng_valid = 1'b0;
        eng_dout  = '0;
        forever begin
            @(negedge clk);
            if (eng_start && !eng_silent) begin
                repeat (eng_lat) @(negedge clk);
                eng_valid = 1'b1;
                eng_dout  = eng_result;
                @(negedge clk);
                eng_valid = 1'b0;
                eng_dout  = '0;
            end
        end
    end

    // Retirement monitor: counts stall cycles and checks each retirement
    initial begin : retire_monitor
        int      stall_cnt;
        retire_t exp;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!nrst || op_code != CUSTOM0 || kill) begin
                stall_cnt = 0;
            end else if (!adv) begin
                stall_cnt++;
            end else begin
                if (retire_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected retire: funct3 %0d, no expectation queued", funct3);
                end else begin
                    exp = retire_q.pop_front();
                    checkOutput({exp.name, " stall"}, 128'(stall_cnt), 128'(exp.stall));
                    checkOutput({exp.name, " rd_data"}, 128'(rd_data), 128'(exp.rd));
                    checkOutput({exp.name, " aes_err"}, 128'(aes_err), 128'(exp.err));
                end
                stall_cnt = 0;
            end
        end
    end

    // Start monitor: each eng_start must be expected, single-cycle, right mode
    initial begin : start_monitor
        logic prev_start;
        logic exp_mode;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (eng_start) begin
                checkOutput("eng_start single pulse", 128'(prev_start), 128'd0);
                if (start_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected eng_start: got 1, expected 0");
                end else begin
                    exp_mode = start_q.pop_front();
                    checkOutput("eng_mode at start", 128'(eng_mode), 128'(exp_mode));
                end
            end
            prev_start = eng_start;
        end
    end

    initial begin : time_guard
        #200000;
        $display("[TB] FAIL global timeout: simulation did not complete");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin : main_seq
        op_code  = NOP_OP;
        funct3   = 3'd0;
        funct7   = 7'd0;
        rs1_data = 32'd0;
        kill     = 1'b0;
        adv      = 1'b0;
        nrst     = 1'b0;

        #12;
        checkOutput("reset aes_done", 128'(aes_done), 128'd1);
        checkOutput("reset rd_data", 128'(rd_data), 128'd0);
        checkOutput("reset aes_err", 128'(aes_err), 128'd0);
        checkOutput("reset eng_start", 128'(eng_start), 128'd0);
        checkOutput("reset eng_mode", 128'(eng_mode), 128'd0);
        checkOutput("reset eng_key", eng_key, 128'd0);
        checkOutput("reset eng_din", eng_din, 128'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        $display("[TB] key and data staging");
        for (int i = 0; i < 4; i++) begin
            expectRetire("keyw", 0, 32'd0, 1'b0);
            applyStimulus(F_KEYW, 2'(i), key_words[i], -1);
        end
        checkOutput("eng_key after KEYW x4", eng_key,
                    128'h0C0D0E0F_08090A0B_04050607_00010203);
        for (int i = 0; i < 4; i++) begin
            expectRetire("datw", 0, 32'd0, 1'b0);
            applyStimulus(F_DATW, 2'(3 - i), din_words[i], -1);
        end
        checkOutput("eng_din after DATW x4", eng_din,
                    128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);

        $display("[TB] ENC with 10-cycle engine");
        eng_silent = 1'b0;
        eng_lat    = 10;
        eng_result = r_enc1;
        start_q.push_back(1'b0);
        expectRetire("enc1", 12, 32'd0, 1'b0);
        applyStimulus(F_ENC, 2'd0, 32'd0, -1);
        expectRetire("rdw0 enc1", 0, 32'hCCDDEEFF, 1'b0);
        applyStimulus(F_RDW, 2'd0, 32'd0, -1);
        expectRetire("rdw3 enc1", 0, 32'h00112233, 1'b0);
        applyStimulus(F_RDW, 2'd3, 32'd0, -1);
        expectRetire("keyw hold", 0, 32'd0, 1'b0);
        applyStimulus(F_KEYW, 2'd0, key_words[0], -1);
        expectRetire("rdw0 after keyw", 0, 32'hCCDDEEFF, 1'b0);
        applyStimulus(F_RDW, 2'd0, 32'd0, -1);

        $display("[TB] back-to-back ENC");
        eng_result = r_enc2;
        start_q.push_back(1'b0);
        expectRetire("enc2", 12, 32'd0, 1'b0);
        applyStimulus(F_ENC, 2'd0, 32'd0, -1);
        eng_result = r_enc3;
        start_q.push_back(1'b0);
        expectRetire("enc3 back-to-back", 12, 32'd0, 1'b0);
        applyStimulus(F_ENC, 2'd0, 32'd0, -1);
        expectRetire("rdw1 enc3", 0, 32'h99AABBCC, 1'b0);
        applyStimulus(F_RDW, 2'd1, 32'd0, -1);
        expectRetire("rdw2 enc3", 0, 32'h55667788, 1'b0);
        applyStimulus(F_RDW, 2'd2, 32'd0, -1);

        $display("[TB] illegal sub-op");
        expectRetire("illegal 111", 0, 32'd0, 1'b0);
        applyStimulus(F_BAD, 2'd0, 32'hFFFFFFFF, -1);
        checkOutput("aes_err after illegal", 128'(aes_err), 128'd1);
        checkOutput("eng_key untouched by illegal", eng_key,
                    128'h0C0D0E0F_08090A0B_04050607_00010203);
        pulseReset();

        $display("[TB] funct3 011");
`ifdef AES_DEC_EN
        eng_result = r_dec;
        start_q.push_back(1'b1);
        expectRetire("dec", 12, 32'd0, 1'b0);
        applyStimulus(F_DEC, 2'd0, 32'd0, -1);
        checkOutput("eng_mode after DEC", 128'(eng_mode), 128'd1);
        expectRetire("rdw0 dec", 0, 32'h0ECA8642, 1'b0);
        applyStimulus(F_RDW, 2'd0, 32'd0, -1);
`else
        expectRetire("dec illegal", 0, 32'd0, 1'b0);
        applyStimulus(F_DEC, 2'd0, 32'h12345678, -1);
        checkOutput("aes_err after 011", 128'(aes_err), 128'd1);
        checkOutput("eng_mode tied low", 128'(eng_mode), 128'd0);
        expectRetire("rdw0 after 011", 0, 32'd0, 1'b1);
        applyStimulus(F_RDW, 2'd0, 32'd0, -1);
`endif
        pulseReset();

        $display("[TB] timeout with silent engine");
        eng_result = r_enc5;
        start_q.push_back(1'b0);
        expectRetire("enc5", 12, 32'd0, 1'b0);
        applyStimulus(F_ENC, 2'd0, 32'd0, -1);
        eng_silent = 1'b1;
        start_q.push_back(1'b0);
        expectRetire("enc timeout", 65, 32'd0, 1'b1);
        applyStimulus(F_ENC, 2'd0, 32'd0, -1);
        expectRetire("rdw2 after timeout", 0, 32'h12345678, 1'b1);
        applyStimulus(F_RDW, 2'd2, 32'd0, -1);

        $display("[TB] kill during BUSY");
        eng_silent = 1'b0;
        eng_lat    = 8;
        eng_result = r_dead;
        start_q.push_back(1'b0);
        applyStimulus(F_ENC, 2'd0, 32'd0, 5);
        expectRetire("rdw2 right after kill", 0, 32'h12345678, 1'b1);
        applyStimulus(F_RDW, 2'd2, 32'd0, -1);
        repeat (8) @(negedge clk);
        expectRetire("rdw0 after late valid", 0, 32'h0BADC0DE, 1'b1);
        applyStimulus(F_RDW, 2'd0, 32'd0, -1);

        $display("[TB] reset during BUSY");
        expectRetire("keyw before reset", 0, 32'd0, 1'b1);
        applyStimulus(F_KEYW, 2'd1, 32'h55AA55AA, -1);
        eng_silent = 1'b1;
        start_q.push_back(1'b0);
        op_code = CUSTOM0;
        funct3  = F_ENC;
        funct7  = 7'd0;
        adv     = 1'b0;
        kill    = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        op_code = NOP_OP;
        #1;
        checkOutput("aes_done low in BUSY with non-custom op", 128'(aes_done), 128'd0);
        nrst = 1'b0;
        #1;
        checkOutput("async reset aes_done", 128'(aes_done), 128'd1);
        checkOutput("async reset aes_err", 128'(aes_err), 128'd0);
        checkOutput("async reset eng_key", eng_key, 128'd0);
        @(negedge clk);
        nrst       = 1'b1;
        eng_silent = 1'b0;
        eng_lat    = 10;
        eng_result = r_enc6;
        start_q.push_back(1'b0);
        expectRetire("enc after reset", 12, 32'd0, 1'b0);
        applyStimulus(F_ENC, 2'd0, 32'd0, -1);
        expectRetire("rdw3 enc6", 0, 32'h76543210, 1'b0);
        applyStimulus(F_RDW, 2'd3, 32'd0, -1);

        repeat (4) @(negedge clk);
        checkOutput("retire queue drained", 128'(retire_q.size()), 128'd0);
        checkOutput("start queue drained", 128'(start_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
